// File: rtl/exec_sequencer_pkg.sv
// exec_sequencer_pkg
// Shared definitions for the execute sequencer: instruction opcodes, the
// execute-unit operation select encoding, FSM state encoding and a helper
// that maps an opcode onto the execute-unit select code.
package exec_sequencer_pkg;

    // Width of the pe_op select bus driven to the execute unit
    localparam int OP_SEL_WIDTH = 2;

    // Instruction opcodes as presented on instr_op
    typedef enum logic [2:0] {
        OP_PASS_B = 3'd0,
        OP_ADD    = 3'd1,
        OP_SUB    = 3'd2,
        OP_MUL    = 3'd3,
        OP_DOT    = 3'd4
    } op_t;

    // Execute-unit operation select codes
    localparam logic [OP_SEL_WIDTH-1:0] PE_OP_PASS_B = 2'b00;
    localparam logic [OP_SEL_WIDTH-1:0] PE_OP_ADD    = 2'b01;
    localparam logic [OP_SEL_WIDTH-1:0] PE_OP_SUB    = 2'b10;
    localparam logic [OP_SEL_WIDTH-1:0] PE_OP_MUL    = 2'b11;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // DOT reuses the multiplier path, so it selects the MUL code.
    // Unknown opcodes fall back to the harmless pass-through.
    function automatic logic [OP_SEL_WIDTH-1:0] pe_op_of(input op_t op);
        logic [OP_SEL_WIDTH-1:0] sel;
        case (op)
            OP_PASS_B: sel = PE_OP_PASS_B;
            OP_ADD:    sel = PE_OP_ADD;
            OP_SUB:    sel = PE_OP_SUB;
            OP_MUL:    sel = PE_OP_MUL;
            OP_DOT:    sel = PE_OP_MUL;
            default:   sel = PE_OP_PASS_B;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/exec_sequencer.sv
// exec_sequencer
// Accepts one instruction at a time, streams its operand chunk(s) to an
// external execute unit, waits the execute-unit latency and returns the
// captured result through a valid/ready response port.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   instr_valid/ready, op, len  instruction handshake, opcode, DOT chunk count
//   opnd_valid/ready, a, b      operand chunk handshake and data
//   a, b, pe_op, dot_prod_en,
//   shift                       registered drive to the execute unit
//   elem_out, dot_out           execute-unit results
//   res_valid/ready, res_data,
//   res_is_dot                  result handshake, data, DOT flag
//
// EXEC_LAT (1..7) counts cycles from the clock edge that applies operands
// to the cycle in which elem_out/dot_out are valid and are captured.
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter int PE_COUNT   = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_CHUNKS = 16,
    parameter int EXEC_LAT   = 1,
    localparam int LEN_W     = $clog2(MAX_CHUNKS + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  instr_valid,
    output logic                                  instr_ready,
    input  logic [2:0]                            instr_op,
    input  logic [LEN_W-1:0]                      instr_len,
    input  logic                                  opnd_valid,
    output logic                                  opnd_ready,
    input  logic [PE_COUNT-1:0][DATA_WIDTH-1:0]   opnd_a,
    input  logic [PE_COUNT-1:0][DATA_WIDTH-1:0]   opnd_b,
    output logic [PE_COUNT-1:0][DATA_WIDTH-1:0]   a,
    output logic [PE_COUNT-1:0][DATA_WIDTH-1:0]   b,
    output logic [OP_SEL_WIDTH-1:0]               pe_op,
    output logic                                  dot_prod_en,
    output logic                                  shift,
    input  logic [PE_COUNT-1:0][DATA_WIDTH-1:0]   elem_out,
    input  logic [PE_COUNT-1:0][DATA_WIDTH-1:0]   dot_out,
    output logic                                  res_valid,
    input  logic                                  res_ready,
    output logic [PE_COUNT-1:0][DATA_WIDTH-1:0]   res_data,
    output logic                                  res_is_dot
);

    typedef logic [PE_COUNT-1:0][DATA_WIDTH-1:0] vec_t;

    state_t                  state_q, state_d;
    op_t                     op_q, op_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic [2:0]              lat_q, lat_d;
    vec_t                    a_q, a_d;
    vec_t                    b_q, b_d;
    logic [OP_SEL_WIDTH-1:0] pe_op_q, pe_op_d;
    logic                    dot_en_q, dot_en_d;
    logic                    shift_q, shift_d;
    logic                    res_valid_q, res_valid_d;
    vec_t                    res_data_q, res_data_d;
    logic                    res_is_dot_q, res_is_dot_d;
    logic                    instr_ready_q, instr_ready_d;
    logic                    opnd_ready_q, opnd_ready_d;

    logic [LEN_W-1:0]        eff_len_s;
    logic [LEN_W-1:0]        cnt_inc_s;

    // Normalise the requested chunk count: zero means one, oversize clamps
    always_comb begin
        if (instr_len == {LEN_W{1'b0}}) begin
            eff_len_s = LEN_W'(1);
        end else if (instr_len > LEN_W'(MAX_CHUNKS)) begin
            eff_len_s = LEN_W'(MAX_CHUNKS);
        end else begin
            eff_len_s = instr_len;
        end
    end

    assign cnt_inc_s = cnt_q + LEN_W'(1);

    // Next-state and next-output computation for the sequencer FSM
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        lat_d         = lat_q;
        a_d           = a_q;
        b_d           = b_q;
        pe_op_d       = pe_op_q;
        dot_en_d      = 1'b0;   // strobes last exactly one cycle
        shift_d       = 1'b0;
        res_valid_d   = res_valid_q;
        res_data_d    = res_data_q;
        res_is_dot_d  = res_is_dot_q;
        instr_ready_d = instr_ready_q;
        opnd_ready_d  = opnd_ready_q;

        case (state_q)
            ST_IDLE: begin
                if (instr_valid && instr_ready_q) begin
                    op_d          = op_t'(instr_op);
                    len_d         = eff_len_s;
                    cnt_d         = {LEN_W{1'b0}};
                    instr_ready_d = 1'b0;
                    opnd_ready_d  = 1'b1;
                    state_d       = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (opnd_valid && opnd_ready_q) begin
                    a_d     = opnd_a;
                    b_d     = opnd_b;
                    pe_op_d = pe_op_of(op_q);
                    if (op_q == OP_DOT) begin
                        dot_en_d = 1'b1;
                        shift_d  = (cnt_q == {LEN_W{1'b0}});
                        cnt_d    = cnt_inc_s;
                        if (cnt_inc_s == len_q) begin
                            opnd_ready_d = 1'b0;
                            lat_d        = 3'd0;
                            state_d      = ST_WAIT;
                        end else begin
                            state_d = ST_ISSUE;
                        end
                    end else begin
                        opnd_ready_d = 1'b0;
                        lat_d        = 3'd0;
                        state_d      = ST_WAIT;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                // The final WAIT cycle is the one in which the execute unit's
                // output is valid, so it is captured at the end of it.
                if (lat_q == 3'(EXEC_LAT - 1)) begin
                    res_data_d   = (op_q == OP_DOT) ? dot_out : elem_out;
                    res_is_dot_d = (op_q == OP_DOT);
                    res_valid_d  = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    lat_d   = lat_q + 3'd1;
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (res_ready && res_valid_q) begin
                    res_valid_d   = 1'b0;
                    instr_ready_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                instr_ready_d = 1'b1;
                opnd_ready_d  = 1'b0;
                res_valid_d   = 1'b0;
            end
        endcase
    end

    // FSM state and registered outputs; reset discards any in-flight work
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_PASS_B;
            len_q         <= {LEN_W{1'b0}};
            cnt_q         <= {LEN_W{1'b0}};
            lat_q         <= 3'd0;
            a_q           <= '0;
            b_q           <= '0;
            pe_op_q       <= PE_OP_PASS_B;
            dot_en_q      <= 1'b0;
            shift_q       <= 1'b0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_is_dot_q  <= 1'b0;
            instr_ready_q <= 1'b1;
            opnd_ready_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            lat_q         <= lat_d;
            a_q           <= a_d;
            b_q           <= b_d;
            pe_op_q       <= pe_op_d;
            dot_en_q      <= dot_en_d;
            shift_q       <= shift_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_is_dot_q  <= res_is_dot_d;
            instr_ready_q <= instr_ready_d;
            opnd_ready_q  <= opnd_ready_d;
        end
    end

    assign instr_ready = instr_ready_q;
    assign opnd_ready  = opnd_ready_q;
    assign a           = a_q;
    assign b           = b_q;
    assign pe_op       = pe_op_q;
    assign dot_prod_en = dot_en_q;
    assign shift       = shift_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_is_dot  = res_is_dot_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer
// Directed bench for exec_sequencer (default parameters, EXEC_LAT=1).
// A small execute-unit model drives elem_out/dot_out combinationally from
// the sequencer's a/b/pe_op, with a lane-wise accumulator for DOT.
module tb_exec_sequencer;

    typedef logic [3:0][7:0] vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_op;
    logic [4:0] instr_len;
    logic       opnd_valid;
    logic       opnd_ready;
    vec_t       opnd_a, opnd_b;
    vec_t       a, b;
    logic [1:0] pe_op;
    logic       dot_prod_en;
    logic       shift;
    vec_t       elem_out, dot_out;
    logic       res_valid;
    logic       res_ready;
    vec_t       res_data;
    logic       res_is_dot;

    int checks   = 0;
    int failures = 0;

    vec_t acc_q;
    vec_t dsum_s;

    exec_sequencer dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_len(instr_len),
        .opnd_valid(opnd_valid), .opnd_ready(opnd_ready),
        .opnd_a(opnd_a), .opnd_b(opnd_b),
        .a(a), .b(b), .pe_op(pe_op), .dot_prod_en(dot_prod_en), .shift(shift),
        .elem_out(elem_out), .dot_out(dot_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_is_dot(res_is_dot)
    );

    always #5 clk = ~clk;

    // Execute-unit model: combinational lane ops and DOT accumulate
    always_comb begin
        elem_out = '0;
        dsum_s   = '0;
        for (int i = 0; i < 4; i++) begin
            case (pe_op)
                2'b00:   elem_out[i] = b[i];
                2'b01:   elem_out[i] = a[i] + b[i];
                2'b10:   elem_out[i] = a[i] - b[i];
                default: elem_out[i] = a[i] * b[i];
            endcase
            dsum_s[i] = (shift ? 8'd0 : acc_q[i]) + a[i] * b[i];
        end
        dot_out = dot_prod_en ? dsum_s : acc_q;
    end

    // Accumulator register of the execute-unit model
    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else if (dot_prod_en) acc_q <= dsum_s;
    end

    function automatic vec_t v4(input int e0, input int e1, input int e2, input int e3);
        vec_t v;
        v[0] = 8'(e0); v[1] = 8'(e1); v[2] = 8'(e2); v[3] = 8'(e3);
        return v;
    endfunction

    // Offers one instruction from the current negedge; returns at the next negedge
    task automatic send_instr(input logic [2:0] op, input logic [4:0] len);
        instr_valid = 1'b1; instr_op = op; instr_len = len;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++; if (opnd_ready !== 1'b0) begin failures++; $display("FAIL reset_opnd_ready got=%b exp=0", opnd_ready); end
        checks++; if ({res_valid, dot_prod_en, shift, res_is_dot} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {res_valid, dot_prod_en, shift, res_is_dot}); end
        checks++; if ({a, b, res_data, pe_op} !== '0) begin failures++; $display("FAIL reset_data got a=%h b=%h rd=%h pe=%b exp=0", a, b, res_data, pe_op); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({instr_ready, opnd_ready} !== 2'b10) begin failures++; $display("FAIL post_reset_ready got=%b exp=10", {instr_ready, opnd_ready}); end
    endtask

    task automatic test_add();
        // cycle T: instruction handshake
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL add_instr_ready got=%b exp=1", instr_ready); end
        send_instr(3'd1, 5'd1);
        // T+1: ISSUE
        checks++; if ({instr_ready, opnd_ready} !== 2'b01) begin failures++; $display("FAIL add_issue_ready got=%b exp=01", {instr_ready, opnd_ready}); end
        opnd_valid = 1'b1; opnd_a = v4(1, 2, 3, 4); opnd_b = v4(16, 32, 48, 64);
        @(negedge clk);
        opnd_valid = 1'b0;
        // T+2: operands applied
        checks++; if (pe_op !== 2'b01) begin failures++; $display("FAIL add_pe_op got=%b exp=01", pe_op); end
        checks++; if (a !== v4(1, 2, 3, 4) || b !== v4(16, 32, 48, 64)) begin failures++; $display("FAIL add_ab got a=%h b=%h", a, b); end
        checks++; if ({res_valid, opnd_ready, dot_prod_en, shift} !== 4'b0000) begin failures++; $display("FAIL add_wait_flags got=%b exp=0000", {res_valid, opnd_ready, dot_prod_en, shift}); end
        @(negedge clk);
        // T+3: result
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL add_res_valid_T3 got=%b exp=1", res_valid); end
        checks++; if (res_data !== v4(17, 34, 51, 68) || res_is_dot !== 1'b0) begin failures++; $display("FAIL add_res_data got=%h dot=%b exp=%h dot=0", res_data, res_is_dot, v4(17, 34, 51, 68)); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++; if ({res_valid, instr_ready} !== 2'b01) begin failures++; $display("FAIL add_back_idle got=%b exp=01", {res_valid, instr_ready}); end
    endtask

    task automatic test_dot_back_to_back();
        int pulses = 0;
        send_instr(3'd4, 5'd4);
        opnd_valid = 1'b1; opnd_a = v4(1, 1, 1, 1); opnd_b = v4(1, 1, 1, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 3) opnd_valid = 1'b0;
            if (dot_prod_en === 1'b1) pulses++;
            checks++; if (shift !== (k == 0)) begin failures++; $display("FAIL dot4_shift_%0d got=%b exp=%b", k, shift, (k == 0)); end
            checks++; if (instr_ready & opnd_ready) begin failures++; $display("FAIL dot4_ready_excl got=%b", {instr_ready, opnd_ready}); end
        end
        checks++; if (pulses !== 4) begin failures++; $display("FAIL dot4_pulses got=%0d exp=4", pulses); end
        @(negedge clk);
        checks++; if (dot_prod_en !== 1'b0 || opnd_ready !== 1'b0) begin failures++; $display("FAIL dot4_after got en=%b ordy=%b exp=0", dot_prod_en, opnd_ready); end
        checks++; if (res_valid !== 1'b1 || res_is_dot !== 1'b1 || res_data !== v4(4, 4, 4, 4)) begin failures++; $display("FAIL dot4_result got v=%b d=%b data=%h exp v=1 d=1 %h", res_valid, res_is_dot, res_data, v4(4, 4, 4, 4)); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_dot_stall();
        int pulses = 0;
        send_instr(3'd4, 5'd2);
        opnd_valid = 1'b1; opnd_a = v4(1, 2, 3, 4); opnd_b = v4(2, 2, 2, 2);
        @(negedge clk);
        opnd_valid = 1'b0; opnd_a = v4(1, 1, 1, 1); opnd_b = v4(5, 6, 7, 8);
        if (dot_prod_en === 1'b1) pulses++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (dot_prod_en === 1'b1) pulses++;
            checks++; if (dot_prod_en !== 1'b0 || shift !== 1'b0) begin failures++; $display("FAIL gap_strobe_%0d got en=%b sh=%b exp=0", k, dot_prod_en, shift); end
            checks++; if (a !== v4(1, 2, 3, 4) || b !== v4(2, 2, 2, 2)) begin failures++; $display("FAIL gap_hold_%0d got a=%h b=%h", k, a, b); end
        end
        opnd_valid = 1'b1;
        @(negedge clk);
        opnd_valid = 1'b0;
        if (dot_prod_en === 1'b1) pulses++;
        checks++; if (shift !== 1'b0 || a !== v4(1, 1, 1, 1)) begin failures++; $display("FAIL gap_chunk2 got sh=%b a=%h", shift, a); end
        @(negedge clk);
        if (dot_prod_en === 1'b1) pulses++;
        checks++; if (pulses !== 2) begin failures++; $display("FAIL gap_pulses got=%0d exp=2", pulses); end
        checks++; if (res_valid !== 1'b1 || res_data !== v4(7, 10, 13, 16)) begin failures++; $display("FAIL gap_result got v=%b data=%h exp %h", res_valid, res_data, v4(7, 10, 13, 16)); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_resp_stall();
        send_instr(3'd2, 5'd1);
        opnd_valid = 1'b1; opnd_a = v4(10, 20, 30, 40); opnd_b = v4(1, 2, 3, 4);
        @(negedge clk);
        opnd_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            checks++; if (res_valid !== 1'b1 || res_data !== v4(9, 18, 27, 36) || instr_ready !== 1'b0) begin failures++; $display("FAIL resp_hold_%0d got v=%b data=%h irdy=%b", k, res_valid, res_data, instr_ready); end
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++; if ({res_valid, instr_ready} !== 2'b01) begin failures++; $display("FAIL resp_release got=%b exp=01", {res_valid, instr_ready}); end
    endtask

    task automatic test_mul();
        send_instr(3'd3, 5'd1);
        opnd_valid = 1'b1; opnd_a = v4(1, 2, 3, 4); opnd_b = v4(2, 3, 4, 5);
        @(negedge clk);
        opnd_valid = 1'b0;
        checks++; if (pe_op !== 2'b11 || dot_prod_en !== 1'b0) begin failures++; $display("FAIL mul_pe_op got=%b en=%b exp=11 0", pe_op, dot_prod_en); end
        @(negedge clk);
        checks++; if (res_data !== v4(2, 6, 12, 20)) begin failures++; $display("FAIL mul_result got=%h exp=%h", res_data, v4(2, 6, 12, 20)); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid_dot();
        int stray = 0;
        send_instr(3'd4, 5'd4);
        opnd_valid = 1'b1; opnd_a = v4(3, 3, 3, 3); opnd_b = v4(3, 3, 3, 3);
        @(negedge clk);
        rst = 1'b1;   // reset lands on the edge that would accept chunk 2
        @(negedge clk);
        rst = 1'b0; opnd_valid = 1'b0;
        checks++; if ({a, b, pe_op, dot_prod_en, shift, res_valid, opnd_ready} !== '0) begin failures++; $display("FAIL midrst_zero got a=%h b=%h pe=%b en=%b sh=%b v=%b or=%b", a, b, pe_op, dot_prod_en, shift, res_valid, opnd_ready); end
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL midrst_instr_ready got=%b exp=1", instr_ready); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (res_valid !== 1'b0) stray++;
        end
        checks++; if (stray !== 0) begin failures++; $display("FAIL midrst_no_resp got=%0d exp=0", stray); end
        send_instr(3'd0, 5'd1);
        opnd_valid = 1'b1; opnd_a = v4(9, 9, 9, 9); opnd_b = v4(5, 6, 7, 8);
        @(negedge clk);
        opnd_valid = 1'b0;
        @(negedge clk);
        checks++; if (res_valid !== 1'b1 || res_data !== v4(5, 6, 7, 8)) begin failures++; $display("FAIL midrst_pass_b got v=%b data=%h exp %h", res_valid, res_data, v4(5, 6, 7, 8)); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_len_zero();
        send_instr(3'd4, 5'd0);
        opnd_valid = 1'b1; opnd_a = v4(3, 3, 3, 3); opnd_b = v4(2, 2, 2, 2);
        @(negedge clk);
        opnd_valid = 1'b0;
        checks++; if ({dot_prod_en, shift, opnd_ready} !== 3'b110) begin failures++; $display("FAIL len0_pulse got=%b exp=110", {dot_prod_en, shift, opnd_ready}); end
        @(negedge clk);
        checks++; if (dot_prod_en !== 1'b0 || res_valid !== 1'b1 || res_data !== v4(6, 6, 6, 6)) begin failures++; $display("FAIL len0_result got en=%b v=%b data=%h", dot_prod_en, res_valid, res_data); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_len_clamp();
        int pulses = 0;
        logic seen = 1'b0;
        send_instr(3'd4, 5'd31);
        opnd_valid = 1'b1; opnd_a = v4(1, 1, 1, 1); opnd_b = v4(1, 1, 1, 1);
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (dot_prod_en === 1'b1) pulses++;
            if (res_valid === 1'b1) seen = 1'b1;
        end
        opnd_valid = 1'b0;
        checks++; if (seen !== 1'b1 || pulses !== 16) begin failures++; $display("FAIL clamp_pulses got seen=%b pulses=%0d exp 1 16", seen, pulses); end
        checks++; if (res_data !== v4(16, 16, 16, 16)) begin failures++; $display("FAIL clamp_result got=%h exp=%h", res_data, v4(16, 16, 16, 16)); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr_op = 3'd0; instr_len = 5'd0;
        opnd_valid = 1'b0; opnd_a = '0; opnd_b = '0; res_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_add();
        test_dot_back_to_back();
        test_dot_stall();
        test_resp_stall();
        test_mul();
        test_reset_mid_dot();
        test_len_zero();
        test_len_clamp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
